// File: rtl/regfile_port_arbiter_if.sv
// Signal bundle between pipeline control and the register-file controller:
// two write requesters, two read ports and the row-level control lines
// (WriteReg, D, ReadEnable1/2) that fan out to the Register_8_Bit rows.
interface regfile_port_arbiter_if #(
  parameter int NUM_REGS = 16,
  parameter int AW       = 4,
  parameter int DW       = 8
);
  // Writeback requester
  logic                wb_valid;
  logic                wb_ready;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  // Load-unit requester
  logic                ld_valid;
  logic                ld_ready;
  logic [AW-1:0]       ld_addr;
  logic [DW-1:0]       ld_data;
  // Read ports
  logic                rd_en1;
  logic [AW-1:0]       rd_addr1;
  logic                rd_en2;
  logic [AW-1:0]       rd_addr2;
  // Register-array control and status
  logic [NUM_REGS-1:0] WriteReg;
  logic [DW-1:0]       D;
  logic [NUM_REGS-1:0] ReadEnable1;
  logic [NUM_REGS-1:0] ReadEnable2;
  logic                init_done;
  logic                rd_hazard1;
  logic                rd_hazard2;
  logic [DW-1:0]       byp_data;

  // Pipeline side: issues requests and read addresses.
  modport master (
    output wb_valid, wb_addr, wb_data,
    output ld_valid, ld_addr, ld_data,
    output rd_en1, rd_addr1, rd_en2, rd_addr2,
    input  wb_ready, ld_ready,
    input  WriteReg, D, ReadEnable1, ReadEnable2,
    input  init_done, rd_hazard1, rd_hazard2, byp_data
  );

  // Controller side: grants requests and drives the row lines.
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  ld_valid, ld_addr, ld_data,
    input  rd_en1, rd_addr1, rd_en2, rd_addr2,
    output wb_ready, ld_ready,
    output WriteReg, D, ReadEnable1, ReadEnable2,
    output init_done, rd_hazard1, rd_hazard2, byp_data
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Register-file controller: clears every row after reset, then arbitrates the
// writeback and load-unit write requesters round-robin onto the shared D bus
// (one write per cycle, driven the cycle after the grant), decodes both read
// addresses to one-hot ReadEnable lines and flags reads of the row being
// written in the same cycle.
// Optional feature: define RF_BYPASS_EN to drive byp_data with the in-flight
// write data while a read hazard is flagged; otherwise byp_data is tied to 0.
module regfile_port_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int ZERO_REG = 1
) (
  input logic                  clk,
  input logic                  rst,
  regfile_port_arbiter_if.slave bus
);

  typedef enum logic { ST_CLEAR, ST_RUN } state_t;
  typedef enum logic { SIDE_WB, SIDE_LD } side_t;

  state_t              state, state_next;
  side_t               rr, rr_next;
  // One bit wider than a row address so it can count one past the last row.
  logic [AW:0]         clr_ptr, clr_ptr_next;
  logic [NUM_REGS-1:0] write_reg, write_reg_next;
  logic [DW-1:0]       d_bus, d_bus_next;
  logic                wb_grant, ld_grant;
  logic                init_done;
  logic [NUM_REGS-1:0] read_en1, read_en2;
  logic                hazard1, hazard2;

  // One-hot decode; addresses beyond the last row decode to all-zero.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [AW-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) oh[i] = (int'(a) == i);
    return oh;
  endfunction

  // Row enable for a requester write: the hardwired zero row is never written.
  function automatic logic [NUM_REGS-1:0] row_enable(input logic [AW-1:0] a);
    if (ZERO_REG != 0 && a == '0) return '0;
    return onehot(a);
  endfunction

  // State register: FSM, clear pointer, round-robin pointer and the write
  // stage that drives the rows one cycle after a grant.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      rr        <= SIDE_WB;
      write_reg <= '0;
      d_bus     <= '0;
    end else begin
      state     <= state_next;
      clr_ptr   <= clr_ptr_next;
      rr        <= rr_next;
      write_reg <= write_reg_next;
      d_bus     <= d_bus_next;
    end
  end

  // Next-state logic: clear sweep in CLEAR, round-robin grant in RUN.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next     = state;
    clr_ptr_next   = clr_ptr;
    rr_next        = rr;
    write_reg_next = '0;
    d_bus_next     = '0;
    wb_grant       = 1'b0;
    ld_grant       = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (int'(clr_ptr) < NUM_REGS) begin
          write_reg_next = onehot(clr_ptr[AW-1:0]);
          clr_ptr_next   = clr_ptr + 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        wb_grant = bus.wb_valid && (!bus.ld_valid || rr == SIDE_WB);
        ld_grant = bus.ld_valid && !wb_grant;
        if (wb_grant) begin
          write_reg_next = row_enable(bus.wb_addr);
          d_bus_next     = bus.wb_data;
          rr_next        = SIDE_LD;
        end else if (ld_grant) begin
          write_reg_next = row_enable(bus.ld_addr);
          d_bus_next     = bus.ld_data;
          rr_next        = SIDE_WB;
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  assign init_done = (state == ST_RUN);

  // Read decode and same-cycle write/read hazard detection.
  always_comb begin
    read_en1 = '0;
    read_en2 = '0;
    if (bus.rd_en1 && init_done) read_en1 = onehot(bus.rd_addr1);
    if (bus.rd_en2 && init_done) read_en2 = onehot(bus.rd_addr2);
    hazard1 = (read_en1 != '0) && (read_en1 == write_reg);
    hazard2 = (read_en2 != '0) && (read_en2 == write_reg);
  end

  assign bus.wb_ready    = wb_grant;
  assign bus.ld_ready    = ld_grant;
  assign bus.WriteReg    = write_reg;
  assign bus.D           = d_bus;
  assign bus.ReadEnable1 = read_en1;
  assign bus.ReadEnable2 = read_en2;
  assign bus.init_done   = init_done;
  assign bus.rd_hazard1  = hazard1;
  assign bus.rd_hazard2  = hazard2;

`ifdef RF_BYPASS_EN
  // Hazarded reads take the value currently on D instead of the stale bitline.
  assign bus.byp_data = (hazard1 || hazard2) ? d_bus : '0;
`else
  assign bus.byp_data = '0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: reset/clear sweep, a table of
// single-cycle vectors, hand-written contention and mid-write reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_regfile_port_arbiter;
  localparam int NUM_REGS = 16;
  localparam int AW       = 4;
  localparam int DW       = 8;

  typedef struct {
    logic          wbv;  logic [3:0] wba; logic [7:0] wbd;
    logic          ldv;  logic [3:0] lda; logic [7:0] ldd;
    logic          r1;   logic [3:0] ra1;
    logic          r2;   logic [3:0] ra2;
    logic          ewbr; logic       eldr;
    logic [15:0]   ewr;  logic       chk_d; logic [7:0] ed;
    logic [15:0]   ere1; logic [15:0] ere2;
    logic          eh1;  logic       eh2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  regfile_port_arbiter_if #(.NUM_REGS(NUM_REGS), .AW(AW), .DW(DW)) bus ();

  regfile_port_arbiter #(
    .NUM_REGS(NUM_REGS), .AW(AW), .DW(DW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t        vecs [13];
  vec_t        v;
  logic [7:0]  exp_byp;
  // Reference model state for the randomized phase.
  bit          m_turn_wb;
  logic [15:0] m_wr;
  logic [7:0]  m_d;
  bit          m_dv;
  logic [3:0]  m_last_addr;
  int          side;
  logic        rwbv, rldv, rre1, rre2;
  logic [3:0]  rwba, rlda, rra1, rra2;
  logic [7:0]  rwbd, rldd;
  logic [15:0] exp_re1, exp_re2;
  logic        exp_h1, exp_h2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.rd_en1 = 1'b0; bus.rd_addr1 = '0;
    bus.rd_en2 = 1'b0; bus.rd_addr2 = '0;
  endtask

  // Bounded wait for the clear sweep to finish.
  task automatic wait_init(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = bus.init_done;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Model: one-hot of an address, zero when outside the file.
  function automatic logic [15:0] exp_onehot(input logic [3:0] a);
    if (int'(a) >= NUM_REGS) return 16'h0000;
    return 16'(32'd1 << a);
  endfunction

  // Model: rows actually written by a requester (row 0 is hardwired zero).
  function automatic logic [15:0] exp_row(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    return exp_onehot(a);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wbv  wba   wbd    ldv  lda   ldd    r1   ra1   r2   ra2   ewbr eldr ewr       chk  ed     ere1      ere2      eh1  eh2
    vecs[0]  = '{1'b1,4'h5,8'hA5, 1'b0,4'h0,8'h00, 1'b0,4'h0, 1'b0,4'h0, 1'b1,1'b0,16'h0000,1'b0,8'h00, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[1]  = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0, 1'b0,4'h0, 1'b0,1'b0,16'h0020,1'b1,8'hA5, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[2]  = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b0,4'h0, 1'b0,4'h0, 1'b0,1'b0,16'h0000,1'b0,8'h00, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[3]  = '{1'b1,4'h1,8'h11, 1'b1,4'h2,8'h22, 1'b0,4'h0, 1'b0,4'h0, 1'b0,1'b1,16'h0000,1'b0,8'h00, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[4]  = '{1'b1,4'h1,8'h11, 1'b1,4'h2,8'h22, 1'b0,4'h0, 1'b0,4'h0, 1'b1,1'b0,16'h0004,1'b1,8'h22, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[5]  = '{1'b1,4'h1,8'h11, 1'b1,4'h2,8'h22, 1'b0,4'h0, 1'b0,4'h0, 1'b0,1'b1,16'h0002,1'b1,8'h11, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[6]  = '{1'b0,4'h0,8'h00, 1'b1,4'h0,8'hFF, 1'b0,4'h0, 1'b0,4'h0, 1'b0,1'b1,16'h0004,1'b1,8'h22, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[7]  = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'h0, 1'b0,4'h0, 1'b0,1'b0,16'h0000,1'b1,8'hFF, 16'h0001,16'h0000,1'b0,1'b0};
    vecs[8]  = '{1'b1,4'h3,8'h3C, 1'b0,4'h0,8'h00, 1'b0,4'h0, 1'b0,4'h0, 1'b1,1'b0,16'h0000,1'b0,8'h00, 16'h0000,16'h0000,1'b0,1'b0};
    vecs[9]  = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'h3, 1'b1,4'h3, 1'b0,1'b0,16'h0008,1'b1,8'h3C, 16'h0008,16'h0008,1'b1,1'b1};
    vecs[10] = '{1'b1,4'hF,8'h77, 1'b0,4'h0,8'h00, 1'b1,4'h4, 1'b0,4'h0, 1'b1,1'b0,16'h0000,1'b0,8'h00, 16'h0010,16'h0000,1'b0,1'b0};
    vecs[11] = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'hF, 1'b1,4'h3, 1'b0,1'b0,16'h8000,1'b1,8'h77, 16'h8000,16'h0008,1'b1,1'b0};
    vecs[12] = '{1'b0,4'h0,8'h00, 1'b0,4'h0,8'h00, 1'b1,4'hF, 1'b0,4'h0, 1'b0,1'b0,16'h0000,1'b0,8'h00, 16'h8000,16'h0000,1'b0,1'b0};

    // ---- Reset and clear sweep (requests held high to prove they wait) ----
    idle_inputs();
    bus.wb_valid = 1'b1; bus.ld_valid = 1'b1;
    bus.rd_en1 = 1'b1; bus.rd_addr1 = 4'd2;
    rst = 1'b0;
    tick();
    tick();
    check("rst_writereg", 32'(bus.WriteReg), 32'h0);
    check("rst_d", 32'(bus.D), 32'h0);
    check("rst_init_done", 32'(bus.init_done), 32'h0);
    check("rst_ready", 32'({bus.wb_ready, bus.ld_ready}), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      tick();
      check($sformatf("clr%0d_writereg", i), 32'(bus.WriteReg), 32'(32'd1 << i));
      check($sformatf("clr%0d_quiet", i),
            32'({bus.D, bus.init_done, bus.wb_ready, bus.ld_ready, bus.ReadEnable1}), 32'h0);
    end
    idle_inputs();
    tick();
    check("clr_end_init_done", 32'(bus.init_done), 32'h1);
    check("clr_end_writereg", 32'(bus.WriteReg), 32'h0);

    // ---- Table-driven vectors (round-robin pointer starts at writeback) ----
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      bus.wb_valid = v.wbv; bus.wb_addr = v.wba; bus.wb_data = v.wbd;
      bus.ld_valid = v.ldv; bus.ld_addr = v.lda; bus.ld_data = v.ldd;
      bus.rd_en1 = v.r1; bus.rd_addr1 = v.ra1;
      bus.rd_en2 = v.r2; bus.rd_addr2 = v.ra2;
      #1;
`ifdef RF_BYPASS_EN
      exp_byp = (v.eh1 || v.eh2) ? v.ed : 8'h00;
`else
      exp_byp = 8'h00;
`endif
      check($sformatf("vec%0d_ready", i), 32'({bus.wb_ready, bus.ld_ready}), 32'({v.ewbr, v.eldr}));
      check($sformatf("vec%0d_writereg", i), 32'(bus.WriteReg), 32'(v.ewr));
      if (v.chk_d) check($sformatf("vec%0d_d", i), 32'(bus.D), 32'(v.ed));
      check($sformatf("vec%0d_re1", i), 32'(bus.ReadEnable1), 32'(v.ere1));
      check($sformatf("vec%0d_re2", i), 32'(bus.ReadEnable2), 32'(v.ere2));
      check($sformatf("vec%0d_hazard", i), 32'({bus.rd_hazard1, bus.rd_hazard2}), 32'({v.eh1, v.eh2}));
      check($sformatf("vec%0d_byp", i), 32'(bus.byp_data), 32'(exp_byp));
      tick();
    end
    idle_inputs();

    // ---- Contention right after reset: grants WB, LD, WB, LD ----
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    wait_init("seqa_init_wait");
    bus.wb_addr = 4'd6; bus.wb_data = 8'h60;
    bus.ld_addr = 4'd9; bus.ld_data = 8'h90;
    for (int i = 0; i < 5; i++) begin
      bus.wb_valid = (i < 4);
      bus.ld_valid = (i < 4);
      #1;
      check($sformatf("seqa%0d_wb_ready", i), 32'(bus.wb_ready), 32'(i < 4 && i % 2 == 0));
      check($sformatf("seqa%0d_ld_ready", i), 32'(bus.ld_ready), 32'(i < 4 && i % 2 == 1));
      if (i > 0) begin
        check($sformatf("seqa%0d_writereg", i), 32'(bus.WriteReg),
              ((i - 1) % 2 == 0) ? 32'h0040 : 32'h0200);
        check($sformatf("seqa%0d_d", i), 32'(bus.D),
              ((i - 1) % 2 == 0) ? 32'h60 : 32'h90);
      end
      tick();
    end
    idle_inputs();

    // ---- Reset asserted while a write is granted: write is lost ----
    bus.wb_valid = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 8'h5A;
    rst = 1'b0;
    #1;
    check("seqb_grant", 32'(bus.wb_ready), 32'h1);
    tick();
    idle_inputs();
    #1;
    check("seqb_writereg", 32'(bus.WriteReg), 32'h0);
    check("seqb_init_done", 32'(bus.init_done), 32'h0);
    rst = 1'b1;
    tick();
    check("seqb_clear_row0", 32'(bus.WriteReg), 32'h0001);
    wait_init("seqb_init_wait");

    // ---- Randomized traffic against the behavioural model ----
    m_turn_wb   = 1'b1;
    m_wr        = 16'h0000;
    m_d         = 8'h00;
    m_dv        = 1'b0;
    m_last_addr = 4'd0;
    for (int n = 0; n < 400; n++) begin
      rwbv = ($urandom_range(0, 9) < 6);
      rldv = ($urandom_range(0, 9) < 6);
      rwba = 4'($urandom_range(0, 15)); rwbd = 8'($urandom);
      rlda = 4'($urandom_range(0, 15)); rldd = 8'($urandom);
      rre1 = ($urandom_range(0, 3) != 0);
      rre2 = ($urandom_range(0, 3) != 0);
      rra1 = ($urandom_range(0, 1) == 1) ? m_last_addr : 4'($urandom_range(0, 15));
      rra2 = ($urandom_range(0, 1) == 1) ? m_last_addr : 4'($urandom_range(0, 15));
      bus.wb_valid = rwbv; bus.wb_addr = rwba; bus.wb_data = rwbd;
      bus.ld_valid = rldv; bus.ld_addr = rlda; bus.ld_data = rldd;
      bus.rd_en1 = rre1; bus.rd_addr1 = rra1;
      bus.rd_en2 = rre2; bus.rd_addr2 = rra2;
      #1;
      if (rwbv && rldv) side = m_turn_wb ? 1 : 2;
      else if (rwbv)    side = 1;
      else if (rldv)    side = 2;
      else              side = 0;
      exp_re1 = rre1 ? exp_onehot(rra1) : 16'h0000;
      exp_re2 = rre2 ? exp_onehot(rra2) : 16'h0000;
      exp_h1  = (exp_re1 != 16'h0000) && (exp_re1 == m_wr);
      exp_h2  = (exp_re2 != 16'h0000) && (exp_re2 == m_wr);
`ifdef RF_BYPASS_EN
      exp_byp = (exp_h1 || exp_h2) ? m_d : 8'h00;
`else
      exp_byp = 8'h00;
`endif
      check("rnd_wb_ready", 32'(bus.wb_ready), 32'(side == 1));
      check("rnd_ld_ready", 32'(bus.ld_ready), 32'(side == 2));
      check("rnd_writereg", 32'(bus.WriteReg), 32'(m_wr));
      if (m_dv) check("rnd_d", 32'(bus.D), 32'(m_d));
      check("rnd_re1", 32'(bus.ReadEnable1), 32'(exp_re1));
      check("rnd_re2", 32'(bus.ReadEnable2), 32'(exp_re2));
      check("rnd_hazard", 32'({bus.rd_hazard1, bus.rd_hazard2}), 32'({exp_h1, exp_h2}));
      check("rnd_byp", 32'(bus.byp_data), 32'(exp_byp));
      if (side == 1) begin
        m_wr = exp_row(rwba); m_d = rwbd; m_dv = 1'b1;
        m_turn_wb = 1'b0; m_last_addr = rwba;
      end else if (side == 2) begin
        m_wr = exp_row(rlda); m_d = rldd; m_dv = 1'b1;
        m_turn_wb = 1'b1; m_last_addr = rlda;
      end else begin
        m_wr = 16'h0000; m_dv = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
